// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between a same-clock producer/consumer and sync_fifo_param.
// master = the pipeline side that drives the requests, slave = the FIFO.
interface sync_fifo_param_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    logic [DATA_W-1:0] rdata;
    logic              flush;
    logic              clr_err;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr, wdata, rd, flush, clr_err,
        input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr, wdata, rd, flush, clr_err,
        output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// registered or first-word-fall-through read, synchronous flush and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    sync_fifo_param_if.slave  fif
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic full_q, full_d, empty_q, empty_d;
    logic af_q, af_d, ae_q, ae_d;
    logic ovf_q, ovf_d, udf_q, udf_d;
    logic rd_ok, wr_ok, rd_en, wr_en;

    // A full FIFO still takes a write when the same cycle pops an entry.
    assign rd_ok = fif.rd & ~empty_q;
    assign wr_ok = fif.wr & (~full_q | rd_ok);
    assign wr_en = wr_ok & ~fif.flush;
    assign rd_en = rd_ok & ~fif.flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (fif.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_en) wptr_d = wptr_q + ADDR_W'(1);
            if (rd_en) rptr_d = rptr_q + ADDR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Flags come from the next count so they line up with the edge that changes it.
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CNT_W'(AF_LEVEL));
        ae_d    = (count_d <= CNT_W'(AE_LEVEL));

        // A fresh error in the clearing cycle wins over clr_err.
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (fif.clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (!fif.flush && fif.wr && !wr_ok) ovf_d = 1'b1;
        if (!fif.flush && fif.rd && empty_q) udf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= fif.wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is always visible; only meaningful while !empty.
            assign fif.rdata = mem_q[rptr_q];
        end else begin : g_reg
            logic [DATA_W-1:0] rdata_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     rdata_q <= '0;
                else if (rd_en) rdata_q <= mem_q[rptr_q];
            end
            assign fif.rdata = rdata_q;
        end
    endgenerate

    assign fif.count        = count_q;
    assign fif.full         = full_q;
    assign fif.empty        = empty_q;
    assign fif.almost_full  = af_q;
    assign fif.almost_empty = ae_q;
    assign fif.overflow     = ovf_q;
    assign fif.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: one registered-read and one FWFT instance share the same stimulus.
module tb_sync_fifo_param;
    localparam int DW = 16;
    localparam int DP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr = 1'b0, rd = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] wdata = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) if0 ();
    sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) if1 ();

    assign if0.wr = wr;  assign if0.wdata = wdata; assign if0.rd = rd;
    assign if0.flush = flush; assign if0.clr_err = clr_err;
    assign if1.wr = wr;  assign if1.wdata = wdata; assign if1.rd = rd;
    assign if1.flush = flush; assign if1.clr_err = clr_err;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(0)) dut0 (.clk(clk), .rst_n(rst_n), .fif(if0));
    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(1)) dut1 (.clk(clk), .rst_n(rst_n), .fif(if1));

    // flags packed as {full, empty, almost_full, almost_empty, overflow, underflow}
    typedef struct {
        logic          wr;
        logic [DW-1:0] wd;
        logic          rd;
        logic          fl;
        logic          ce;
        int            cnt;
        logic [5:0]    flg;
        logic          c0;
        logic [DW-1:0] r0;
        logic          c1;
        logic [DW-1:0] r1;
    } vec_t;

    vec_t v[$];

    function automatic void add(input logic w, input logic [DW-1:0] wd, input logic r,
                                input logic fl, input logic ce, input int cnt,
                                input logic [5:0] flg, input logic c0, input logic [DW-1:0] r0,
                                input logic c1, input logic [DW-1:0] r1);
        vec_t e;
        e.wr = w; e.wd = wd; e.rd = r; e.fl = fl; e.ce = ce; e.cnt = cnt;
        e.flg = flg; e.c0 = c0; e.r0 = r0; e.c1 = c1; e.r1 = r1;
        v.push_back(e);
    endfunction

    function automatic logic [5:0] mkflg(input int cnt, input logic ovf, input logic udf);
        mkflg = {cnt == DP, cnt == 0, cnt >= DP - 2, cnt <= 2, ovf, udf};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    task automatic drive(input logic w, input logic [DW-1:0] wd, input logic r,
                         input logic fl, input logic ce);
        wr = w; wdata = wd; rd = r; flush = fl; clr_err = ce;
    endtask

    function automatic logic [5:0] flags0();
        flags0 = {if0.full, if0.empty, if0.almost_full, if0.almost_empty, if0.overflow, if0.underflow};
    endfunction

    function automatic logic [5:0] flags1();
        flags1 = {if1.full, if1.empty, if1.almost_full, if1.almost_empty, if1.overflow, if1.underflow};
    endfunction

    // Apply one input set at the falling edge, sample #1 after the rising edge.
    task automatic cyc(input logic w, input logic [DW-1:0] wd, input logic r,
                       input logic fl, input logic ce);
        @(negedge clk);
        drive(w, wd, r, fl, ce);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // fill 1..8, overflow + clear, full-with-read replacement, drain, underflow cases
        for (int k = 1; k <= 8; k++)
            add(1, DW'(k), 0, 0, 0, k, mkflg(k, 0, 0), 1, 16'h0000, 1, 16'h0001);
        add(1, 16'h0099, 0, 0, 0, 8, mkflg(8, 1, 0), 1, 16'h0000, 1, 16'h0001);
        add(0, 16'h0000, 0, 0, 1, 8, mkflg(8, 0, 0), 1, 16'h0000, 1, 16'h0001);
        add(1, 16'h00AA, 1, 0, 0, 8, mkflg(8, 0, 0), 1, 16'h0001, 1, 16'h0002);
        for (int j = 1; j <= 8; j++)
            add(0, 16'h0000, 1, 0, 0, 8 - j, mkflg(8 - j, 0, 0),
                1, (j < 8) ? DW'(j + 1) : 16'h00AA,
                j < 8, (j < 7) ? DW'(j + 2) : 16'h00AA);
        add(0, 16'h0000, 1, 0, 0, 0, mkflg(0, 0, 1), 1, 16'h00AA, 0, 16'h0000);
        add(0, 16'h0000, 0, 0, 1, 0, mkflg(0, 0, 0), 1, 16'h00AA, 0, 16'h0000);
        add(1, 16'h0055, 1, 0, 0, 1, mkflg(1, 0, 1), 1, 16'h00AA, 1, 16'h0055);
        add(0, 16'h0000, 1, 0, 1, 0, mkflg(0, 0, 0), 1, 16'h0055, 0, 16'h0000);

        drive(0, '0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset count", 32'(if0.count), 32'd0);
        chk("reset flags", 32'(flags0()), 32'(mkflg(0, 0, 0)));
        chk("reset rdata", 32'(if0.rdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (v[i]) begin
            cyc(v[i].wr, v[i].wd, v[i].rd, v[i].fl, v[i].ce);
            chk($sformatf("v%0d count", i), 32'(if0.count), 32'(v[i].cnt));
            chk($sformatf("v%0d flags0", i), 32'(flags0()), 32'(v[i].flg));
            chk($sformatf("v%0d flags1", i), 32'(flags1()), 32'(v[i].flg));
            if (v[i].c0) chk($sformatf("v%0d rdata0", i), 32'(if0.rdata), 32'(v[i].r0));
            if (v[i].c1) chk($sformatf("v%0d rdata1", i), 32'(if1.rdata), 32'(v[i].r1));
        end

        // 20-word stream, one word in flight, crossing the pointer wrap
        cyc(1, 16'h0100, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            drive(i < 20, DW'(16'h0100 + i), 1, 0, 0);
            #1;
            chk($sformatf("stream%0d fwft", i), 32'(if1.rdata), 32'(16'h0100 + i - 1));
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d reg", i), 32'(if0.rdata), 32'(16'h0100 + i - 1));
            chk($sformatf("stream%0d count", i), 32'(if0.count), (i < 20) ? 32'd1 : 32'd0);
        end

        // flush with a concurrent write
        for (int i = 0; i < 5; i++) cyc(1, DW'(16'h0030 + i), 0, 0, 0);
        chk("pre-flush count", 32'(if0.count), 32'd5);
        cyc(1, 16'h00EE, 0, 1, 0);
        chk("flush count", 32'(if0.count), 32'd0);
        chk("flush flags", 32'(flags0()), 32'(mkflg(0, 0, 0)));
        chk("flush rdata kept", 32'(if0.rdata), 32'h0113);
        cyc(1, 16'h0077, 0, 0, 0);
        chk("post-flush fwft", 32'(if1.rdata), 32'h0077);
        cyc(0, '0, 1, 0, 0);
        chk("post-flush reg", 32'(if0.rdata), 32'h0077);
        chk("post-flush count", 32'(if0.count), 32'd0);

        // reset mid-operation discards contents
        cyc(1, 16'h0011, 0, 0, 0);
        cyc(1, 16'h0022, 0, 0, 0);
        @(negedge clk);
        drive(0, '0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst count", 32'(if0.count), 32'd0);
        chk("midrst flags", 32'(flags0()), 32'(mkflg(0, 0, 0)));
        chk("midrst rdata", 32'(if0.rdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 16'h0033, 0, 0, 0);
        cyc(0, '0, 1, 0, 0);
        chk("after rst read", 32'(if0.rdata), 32'h0033);
        chk("after rst count", 32'(if0.count), 32'd0);

        drive(0, '0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
